// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: stage-count helpers and op encoding.
package adder_pipe_pkg;

  // Operation encoding carried on the 'sub' input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of CHUNK-bit slices (and slice-add stages) for a WIDTH-bit operand.
  function automatic int unsigned nch(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Enabled edges from input capture to registered result: one input stage plus one per slice.
  function automatic int unsigned lat(input int unsigned width, input int unsigned chunk);
    return nch(width, chunk) + 1;
  endfunction

endpackage

// File: rtl/adder_sub_pipe_gen_chunk.sv
// Combinational CHUNK-bit slice adder with carry in and carry out.
module adder_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // One extra bit catches the slice carry-out.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_sub_pipe_gen.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, carry registered between stages,
// operand skew and result deskew so the full result emerges at once. Valid/tag ride alongside,
// 'en' stalls the whole pipe. Reports carry-out and signed overflow.
// Optional build macro ADDER_PIPE_SAT_EN: saturate the result to signed MIN/MAX on overflow.
module adder_sub_pipe_gen
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned NCH = nch(WIDTH, CHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_width_chk
    $error("adder_sub_pipe_gen: WIDTH must be a multiple of CHUNK");
  end

  localparam logic [WIDTH-1:0] SignedMin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SignedMax = {1'b0, {(WIDTH-1){1'b1}}};

  // Subtraction is a + ~b + 1; the +1 enters as slice-0 carry-in.
  logic [WIDTH-1:0] b_eff;
  assign b_eff = (sub == OP_SUB) ? ~b : b;

  logic                      sub_q;      // stage-0 copy of sub, slice-0 carry-in
  logic [NCH:0]              vld_q;      // vld_q[s] = valid at stage s
  logic [NCH:0][TAG_W-1:0]   tag_q;      // tag_q[s] = tag at stage s
  logic [NCH-1:0]            co_w;       // combinational slice carry-outs
  logic [NCH-1:0]            carry_q;    // carry_q[k] = carry-out of slice k, at stage k+1
  logic [WIDTH-1:0]          raw_sum;    // deskewed result at stage NCH
  logic                      a_top_w;    // operand MSBs leaving the top slice stage
  logic                      bp_top_w;
  logic                      a_msb_q;    // operand MSBs aligned with raw_sum
  logic                      bp_msb_q;

  // Valid/tag pipe, inter-slice carries and operand sign bits; all hold while en=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q    <= 1'b0;
      vld_q    <= '0;
      tag_q    <= '0;
      carry_q  <= '0;
      a_msb_q  <= 1'b0;
      bp_msb_q <= 1'b0;
    end else if (en) begin
      sub_q    <= sub;
      vld_q    <= {vld_q[NCH-1:0], in_valid};
      tag_q    <= {tag_q[NCH-1:0], in_tag};
      carry_q  <= co_w;
      a_msb_q  <= a_top_w;
      bp_msb_q <= bp_top_w;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slice
    localparam int unsigned LO = k * CHUNK;

    // Operand skew: index j is the copy at stage j; slice k is consumed at stage k.
    logic [k:0][CHUNK-1:0]       a_sk_q, a_sk_d, bp_sk_q, bp_sk_d;
    // Result deskew: index s is the copy at stage s; slice k result is born at stage k+1.
    logic [NCH:k+1][CHUNK-1:0]   s_sk_q, s_sk_d;
    logic                        cin;
    logic [CHUNK-1:0]            s_w;

    if (k == 0) begin : g_cin_first
      assign cin     = sub_q;
      assign a_sk_d  = a[LO +: CHUNK];
      assign bp_sk_d = b_eff[LO +: CHUNK];
    end else begin : g_cin_chain
      assign cin     = carry_q[k-1];
      assign a_sk_d  = {a_sk_q[k-1:0], a[LO +: CHUNK]};
      assign bp_sk_d = {bp_sk_q[k-1:0], b_eff[LO +: CHUNK]};
    end

    if (k == NCH - 1) begin : g_deskew_last
      assign s_sk_d   = s_w;
      assign a_top_w  = a_sk_q[k][CHUNK-1];
      assign bp_top_w = bp_sk_q[k][CHUNK-1];
    end else begin : g_deskew_shift
      assign s_sk_d = {s_sk_q[NCH-1:k+1], s_w};
    end

    adder_chunk #(
      .W (CHUNK)
    ) u_add (
      .a    (a_sk_q[k]),
      .b    (bp_sk_q[k]),
      .cin  (cin),
      .s    (s_w),
      .cout (co_w[k])
    );

    // Advance this slice's skew and deskew shift registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_sk_q  <= '0;
        bp_sk_q <= '0;
        s_sk_q  <= '0;
      end else if (en) begin
        a_sk_q  <= a_sk_d;
        bp_sk_q <= bp_sk_d;
        s_sk_q  <= s_sk_d;
      end
    end

    assign raw_sum[LO +: CHUNK] = s_sk_q[NCH];
  end

  // Signed overflow: operands agree in sign but the raw result does not.
  logic ovf_w;
  assign ovf_w = (a_msb_q == bp_msb_q) && (raw_sum[WIDTH-1] != a_msb_q);

  logic [WIDTH-1:0] sum_d;

  // Result select ahead of the output register.
  always_comb begin
    sum_d = raw_sum;
`ifdef ADDER_PIPE_SAT_EN
    if (ovf_w) begin
      sum_d = a_msb_q ? SignedMin : SignedMax;
    end
`endif
  end

  // Output register: result fields update only when a valid op emerges.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= vld_q[NCH];
      if (vld_q[NCH]) begin
        sum     <= sum_d;
        cout    <= carry_q[NCH-1];
        ovf     <= ovf_w;
        out_tag <= tag_q[NCH];
      end
    end
  end

endmodule

// File: tb/tb_adder_sub_pipe_gen.sv
// Scoreboard bench for adder_sub_pipe_gen (16/4/4, latency 5). Stimulus pushes hand-computed
// expectations with the enabled-edge count at which each result must appear; a monitor checks
// every enabled cycle for a matching result, a bubble, or the reset state.
module tb_adder_sub_pipe_gen;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned TAG_W = 4;
  localparam int          LAT   = 5;
`ifdef ADDER_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, en, in_valid, sub;
  logic [WIDTH-1:0] a, b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, cout, ovf;
  logic [WIDTH-1:0] sum;
  logic [TAG_W-1:0] out_tag;

  adder_sub_pipe_gen #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_edges = 0;
  bit   last_reset = 1'b0;
  bit   last_en    = 1'b0;

  // Track what the DUT saw at each rising edge.
  always @(posedge clk) begin
    last_reset <= reset;
    last_en    <= en;
    if (en && !reset) en_edges <= en_edges + 1;
  end

  // Monitor: compare on the falling edge after every reset or enabled edge.
  always @(negedge clk) begin
    exp_t e;
    if (last_reset) begin
      n_tests++;
      if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0
          || out_tag !== '0) begin
        n_fail++;
        $display("FAIL reset_state: got v=%0b sum=%h c=%0b o=%0b tag=%h, want all zero",
                 out_valid, sum, cout, ovf, out_tag);
      end
    end else if (last_en) begin
      n_tests++;
      if (sb.size() > 0 && sb[0].due == en_edges) begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf
            || out_tag !== e.tag) begin
          n_fail++;
          $display("FAIL result_tag%0d: got v=%0b sum=%h c=%0b o=%0b tag=%h, want v=1 sum=%h c=%0b o=%0b tag=%h",
                   e.tag, out_valid, sum, cout, ovf, out_tag, e.sum, e.cout, e.ovf, e.tag);
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got v=%b sum=%h tag=%h at edge %0d, want v=0",
                 out_valid, sum, out_tag, en_edges);
      end
    end
  end

  // Issue one op on the next edge and record its expected result.
  task automatic issue(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] es,
                       input logic ec, input logic eo);
    exp_t e;
    en = 1'b1; in_valid = 1'b1; sub = s; a = av; b = bv; in_tag = t;
    e.sum = es; e.cout = ec; e.ovf = eo; e.tag = t; e.due = en_edges + 1 + LAT;
    sb.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    idle(2);

    // Single op, carry ripples across slices 0..2.
    issue(1'b0, 16'h00FF, 16'h0001, 4'd3, 16'h0100, 1'b0, 1'b0);
    idle(LAT + 1);
    // Carry through all four slices.
    issue(1'b0, 16'hFFFF, 16'h0001, 4'd1, 16'h0000, 1'b1, 1'b0);
    idle(1);
    issue(1'b1, 16'h0005, 16'h0007, 4'd2, 16'hFFFE, 1'b0, 1'b0);
    issue(1'b1, 16'h8000, 16'h0001, 4'd4, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
    issue(1'b0, 16'h7FFF, 16'h0001, 4'd5, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    idle(2);

    // Eight back-to-back ops with a 3-cycle stall after the fourth.
    issue(1'b0, 16'h1234, 16'h1111, 4'd0, 16'h2345, 1'b0, 1'b0);
    issue(1'b0, 16'h0F0F, 16'h00F1, 4'd1, 16'h1000, 1'b0, 1'b0);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 4'd2, 16'hFFFE, 1'b1, 1'b0);
    issue(1'b0, 16'h8000, 16'h8000, 4'd3, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
    en = 1'b0; in_valid = 1'b1; sub = 1'b1; a = 16'hDEAD; b = 16'hBEEF; in_tag = 4'hF;
    repeat (3) begin
      @(posedge clk); #2;
    end
    en = 1'b1; in_valid = 1'b0;
    issue(1'b1, 16'h1000, 16'h0001, 4'd4, 16'h0FFF, 1'b1, 1'b0);
    issue(1'b1, 16'h0000, 16'h0000, 4'd5, 16'h0000, 1'b1, 1'b0);
    issue(1'b1, 16'h7FFF, 16'hFFFF, 4'd6, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    issue(1'b1, 16'h1234, 16'h1234, 4'd7, 16'h0000, 1'b1, 1'b0);
    idle(LAT + 2);

    // Three ops in flight, then a one-cycle reset discards them.
    issue(1'b0, 16'h0001, 16'h0001, 4'd10, 16'h0002, 1'b0, 1'b0);
    issue(1'b0, 16'h0002, 16'h0002, 4'd11, 16'h0004, 1'b0, 1'b0);
    issue(1'b0, 16'h0003, 16'h0003, 4'd12, 16'h0006, 1'b0, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    idle(LAT + 2);
    issue(1'b1, 16'h1234, 16'h0FFF, 4'd9, 16'h0235, 1'b1, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    idle(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
